// File: rtl/ofs_asp_pkg.sv
// Shared types and helpers for the host memory read/write multiplexer.
package ofs_asp_pkg;

   localparam int ARB_RR     = 0;   // round-robin arbitration
   localparam int ARB_FIXED  = 1;   // fixed priority, lowest index wins

   localparam int SRC_ID_W   = 3;   // enough for up to 8 sources
   localparam int ROUTE_BC_W = 16;  // burstcount slot in a route entry

   typedef struct packed {
      logic [SRC_ID_W-1:0]   src_id;
      logic [ROUTE_BC_W-1:0] burstcount;
   } route_entry_t;

   typedef enum logic {
      WR_IDLE  = 1'b0,
      WR_BURST = 1'b1
   } wr_state_e;

   // Returns {found, index}. The scan runs from lowest to highest priority
   // so the last hit written is the winner.
   function automatic logic [SRC_ID_W:0] arb_pick(input logic [7:0] req,
                                                   input logic [SRC_ID_W-1:0] ptr,
                                                   input int num,
                                                   input int mode);
      logic [SRC_ID_W:0] res;
      int idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         if (k < num) begin
            idx = (mode == ARB_FIXED) ? k : (int'(ptr) + k) % num;
            if (req[idx[SRC_ID_W-1:0]]) res = {1'b1, idx[SRC_ID_W-1:0]};
         end
      end
      return res;
   endfunction

   // Pointer value one past the winner, wrapping at num.
   function automatic logic [SRC_ID_W-1:0] ptr_next(input logic [SRC_ID_W-1:0] win,
                                                     input int num);
      return (int'(win) == num - 1) ? '0 : win + 1'b1;
   endfunction

endpackage

// File: rtl/host_mem_mux_route_fifo.sv
// Route FIFO: remembers which source owns each outstanding burst.
module host_mem_mux_route_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; push+pop together leaves count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy guards them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/host_mem_rdwr_mux_n.sv
// N-to-1 Avalon read/write multiplexer with independent read and write
// arbitration and per-channel route FIFOs for steering responses back.
module host_mem_rdwr_mux_n
   import ofs_asp_pkg::*;
#(
   parameter int NUM_SOURCES = 2,
   parameter int ADDR_W      = 48,
   parameter int DATA_W      = 512,
   parameter int BC_W        = 7,
   parameter int USER_W      = 8,
   parameter int MAX_OUTST   = 64,
   parameter int ARB_MODE    = 0
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_SOURCES-1:0]          src_rd_read,
   input  logic [NUM_SOURCES*ADDR_W-1:0]   src_rd_address,
   input  logic [NUM_SOURCES*BC_W-1:0]     src_rd_burstcount,
   input  logic [NUM_SOURCES*DATA_W/8-1:0] src_rd_byteenable,
   input  logic [NUM_SOURCES*USER_W-1:0]   src_rd_user,
   output logic [NUM_SOURCES-1:0]          src_rd_waitrequest,
   output logic [DATA_W-1:0]               src_rd_readdata,
   output logic [1:0]                      src_rd_response,
   output logic [NUM_SOURCES-1:0]          src_rd_readdatavalid,
   input  logic [NUM_SOURCES-1:0]          src_wr_write,
   input  logic [NUM_SOURCES*ADDR_W-1:0]   src_wr_address,
   input  logic [NUM_SOURCES*BC_W-1:0]     src_wr_burstcount,
   input  logic [NUM_SOURCES*DATA_W-1:0]   src_wr_writedata,
   input  logic [NUM_SOURCES*DATA_W/8-1:0] src_wr_byteenable,
   input  logic [NUM_SOURCES*USER_W-1:0]   src_wr_user,
   output logic [NUM_SOURCES-1:0]          src_wr_waitrequest,
   output logic [NUM_SOURCES-1:0]          src_wr_writeresponsevalid,
   output logic                            snk_rd_read,
   output logic [ADDR_W-1:0]               snk_rd_address,
   output logic [BC_W-1:0]                 snk_rd_burstcount,
   output logic [DATA_W/8-1:0]             snk_rd_byteenable,
   output logic [USER_W-1:0]               snk_rd_user,
   input  logic                            snk_rd_waitrequest,
   input  logic [DATA_W-1:0]               snk_rd_readdata,
   input  logic [1:0]                      snk_rd_response,
   input  logic                            snk_rd_readdatavalid,
   output logic                            snk_wr_write,
   output logic [ADDR_W-1:0]               snk_wr_address,
   output logic [BC_W-1:0]                 snk_wr_burstcount,
   output logic [DATA_W-1:0]               snk_wr_writedata,
   output logic [DATA_W/8-1:0]             snk_wr_byteenable,
   output logic [USER_W-1:0]               snk_wr_user,
   input  logic                            snk_wr_waitrequest,
   input  logic                            snk_wr_writeresponsevalid,
   output logic                            route_err
);

   localparam int BE_W = DATA_W / 8;

   // ---------------- read channel ----------------
   logic [SRC_ID_W:0]     rd_pick;
   logic                  rd_found;
   logic [SRC_ID_W-1:0]   rd_win;
   logic [SRC_ID_W-1:0]   rd_ptr;
   logic                  rd_full, rd_empty, rd_accept, rd_resp_ok, rd_pop;
   route_entry_t          rd_head, rd_push_entry;
   logic [ROUTE_BC_W-1:0] rd_beats_left, rd_rem;

   assign rd_pick  = arb_pick(8'(src_rd_read), rd_ptr, NUM_SOURCES, ARB_MODE);
   assign rd_found = rd_pick[SRC_ID_W];
   assign rd_win   = rd_pick[SRC_ID_W-1:0];

   assign snk_rd_read       = reset_n && rd_found && !rd_full;
   assign snk_rd_address    = src_rd_address[int'(rd_win)*ADDR_W +: ADDR_W];
   assign snk_rd_burstcount = src_rd_burstcount[int'(rd_win)*BC_W +: BC_W];
   assign snk_rd_byteenable = src_rd_byteenable[int'(rd_win)*BE_W +: BE_W];
   assign snk_rd_user       = src_rd_user[int'(rd_win)*USER_W +: USER_W];
   assign rd_accept         = snk_rd_read && !snk_rd_waitrequest;

   assign rd_push_entry.src_id     = rd_win;
   assign rd_push_entry.burstcount = ROUTE_BC_W'(snk_rd_burstcount);

   // A zero beat counter means "not yet loaded from the head entry".
   assign rd_resp_ok = reset_n && snk_rd_readdatavalid && !rd_empty;
   assign rd_rem     = (rd_beats_left == '0) ? rd_head.burstcount : rd_beats_left;
   assign rd_pop     = rd_resp_ok && (rd_rem == ROUTE_BC_W'(1));

   assign src_rd_readdata = snk_rd_readdata;
   assign src_rd_response = snk_rd_response;

   host_mem_mux_route_fifo #(
      .WIDTH ($bits(route_entry_t)),
      .DEPTH (MAX_OUTST)
   ) u_rd_route (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rd_accept),
      .push_data (rd_push_entry),
      .pop       (rd_pop),
      .head      (rd_head),
      .empty     (rd_empty),
      .full      (rd_full)
   );

   // Read beat counter and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_beats_left <= '0;
         rd_ptr        <= '0;
      end else begin
         if (rd_resp_ok) rd_beats_left <= rd_pop ? '0 : rd_rem - 1'b1;
         if (ARB_MODE == ARB_RR && rd_accept) rd_ptr <= ptr_next(rd_win, NUM_SOURCES);
      end
   end

   // ---------------- write channel ----------------
   wr_state_e           wr_state, wr_state_nxt;
   logic [SRC_ID_W:0]   wr_pick;
   logic                wr_found;
   logic [SRC_ID_W-1:0] wr_win, wr_lock, wr_lock_nxt, wr_ptr, wr_sel, wr_head;
   logic [BC_W-1:0]     wr_rem, wr_rem_nxt;
   logic [7:0]          wr_req8;
   logic                wr_full, wr_empty, wr_sel_vld, wr_accept;
   logic                wr_push, wr_done, wr_resp_ok;

   assign wr_req8  = 8'(src_wr_write);
   assign wr_pick  = arb_pick(wr_req8, wr_ptr, NUM_SOURCES, ARB_MODE);
   assign wr_found = wr_pick[SRC_ID_W];
   assign wr_win   = wr_pick[SRC_ID_W-1:0];

   // Inside a burst only the locked source is served and the FIFO never blocks it.
   assign wr_sel     = (wr_state == WR_BURST) ? wr_lock : wr_win;
   assign wr_sel_vld = (wr_state == WR_BURST) ? wr_req8[wr_lock] : (wr_found && !wr_full);

   assign snk_wr_write      = reset_n && wr_sel_vld;
   assign snk_wr_address    = src_wr_address[int'(wr_sel)*ADDR_W +: ADDR_W];
   assign snk_wr_burstcount = src_wr_burstcount[int'(wr_sel)*BC_W +: BC_W];
   assign snk_wr_writedata  = src_wr_writedata[int'(wr_sel)*DATA_W +: DATA_W];
   assign snk_wr_byteenable = src_wr_byteenable[int'(wr_sel)*BE_W +: BE_W];
   assign snk_wr_user       = src_wr_user[int'(wr_sel)*USER_W +: USER_W];
   assign wr_accept         = snk_wr_write && !snk_wr_waitrequest;
   assign wr_resp_ok        = reset_n && snk_wr_writeresponsevalid && !wr_empty;

   host_mem_mux_route_fifo #(
      .WIDTH (SRC_ID_W),
      .DEPTH (MAX_OUTST)
   ) u_wr_route (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (wr_push),
      .push_data (wr_sel),
      .pop       (wr_resp_ok),
      .head      (wr_head),
      .empty     (wr_empty),
      .full      (wr_full)
   );

   // Write FSM state register and burst bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_state <= WR_IDLE;
         wr_lock  <= '0;
         wr_rem   <= '0;
         wr_ptr   <= '0;
      end else begin
         wr_state <= wr_state_nxt;
         wr_lock  <= wr_lock_nxt;
         wr_rem   <= wr_rem_nxt;
         if (ARB_MODE == ARB_RR && wr_done) wr_ptr <= ptr_next(wr_sel, NUM_SOURCES);
      end
   end

   // Write FSM next state: first beat pushes the route, multi-beat bursts lock.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_lock_nxt  = wr_lock;
      wr_rem_nxt   = wr_rem;
      wr_push      = 1'b0;
      wr_done      = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (wr_accept) begin
               wr_push = 1'b1;
               if (snk_wr_burstcount > BC_W'(1)) begin
                  wr_state_nxt = WR_BURST;
                  wr_lock_nxt  = wr_win;
                  wr_rem_nxt   = snk_wr_burstcount - 1'b1;
               end else begin
                  wr_done = 1'b1;
               end
            end
         end
         WR_BURST: begin
            if (wr_accept) begin
               wr_rem_nxt = wr_rem - 1'b1;
               if (wr_rem == BC_W'(1)) begin
                  wr_state_nxt = WR_IDLE;
                  wr_done      = 1'b1;
               end
            end
         end
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   // Per-source handshakes decoded from the granted or head source id.
   always_comb begin
      src_rd_waitrequest        = '1;
      src_rd_readdatavalid      = '0;
      src_wr_waitrequest        = '1;
      src_wr_writeresponsevalid = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         src_rd_waitrequest[i]        = !(rd_accept && rd_win == SRC_ID_W'(i));
         src_rd_readdatavalid[i]      = rd_resp_ok && rd_head.src_id == SRC_ID_W'(i);
         src_wr_waitrequest[i]        = !(wr_accept && wr_sel == SRC_ID_W'(i));
         src_wr_writeresponsevalid[i] = wr_resp_ok && wr_head == SRC_ID_W'(i);
      end
   end

   // Sticky flag for responses that have no route entry to follow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         route_err <= 1'b0;
      end else if ((snk_rd_readdatavalid && rd_empty) ||
                   (snk_wr_writeresponsevalid && wr_empty)) begin
         route_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_host_mem_rdwr_mux_n.sv
// Directed bench for host_mem_rdwr_mux_n: 4 sources, route FIFOs of depth 4.
module tb_host_mem_rdwr_mux_n;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int UW = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    src_rd_read;
   logic [N*AW-1:0] src_rd_address;
   logic [N*BW-1:0] src_rd_burstcount;
   logic [N*DW/8-1:0] src_rd_byteenable;
   logic [N*UW-1:0] src_rd_user;
   logic [N-1:0]    src_rd_waitrequest;
   logic [DW-1:0]   src_rd_readdata;
   logic [1:0]      src_rd_response;
   logic [N-1:0]    src_rd_readdatavalid;
   logic [N-1:0]    src_wr_write;
   logic [N*AW-1:0] src_wr_address;
   logic [N*BW-1:0] src_wr_burstcount;
   logic [N*DW-1:0] src_wr_writedata;
   logic [N*DW/8-1:0] src_wr_byteenable;
   logic [N*UW-1:0] src_wr_user;
   logic [N-1:0]    src_wr_waitrequest;
   logic [N-1:0]    src_wr_writeresponsevalid;
   logic            snk_rd_read;
   logic [AW-1:0]   snk_rd_address;
   logic [BW-1:0]   snk_rd_burstcount;
   logic [DW/8-1:0] snk_rd_byteenable;
   logic [UW-1:0]   snk_rd_user;
   logic            snk_rd_waitrequest;
   logic [DW-1:0]   snk_rd_readdata;
   logic [1:0]      snk_rd_response;
   logic            snk_rd_readdatavalid;
   logic            snk_wr_write;
   logic [AW-1:0]   snk_wr_address;
   logic [BW-1:0]   snk_wr_burstcount;
   logic [DW-1:0]   snk_wr_writedata;
   logic [DW/8-1:0] snk_wr_byteenable;
   logic [UW-1:0]   snk_wr_user;
   logic            snk_wr_waitrequest;
   logic            snk_wr_writeresponsevalid;
   logic            route_err;

   int total = 0;
   int bad   = 0;

   host_mem_rdwr_mux_n #(
      .NUM_SOURCES (N), .ADDR_W (AW), .DATA_W (DW), .BC_W (BW),
      .USER_W (UW), .MAX_OUTST (4), .ARB_MODE (0)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .src_rd_read (src_rd_read), .src_rd_address (src_rd_address),
      .src_rd_burstcount (src_rd_burstcount), .src_rd_byteenable (src_rd_byteenable),
      .src_rd_user (src_rd_user), .src_rd_waitrequest (src_rd_waitrequest),
      .src_rd_readdata (src_rd_readdata), .src_rd_response (src_rd_response),
      .src_rd_readdatavalid (src_rd_readdatavalid),
      .src_wr_write (src_wr_write), .src_wr_address (src_wr_address),
      .src_wr_burstcount (src_wr_burstcount), .src_wr_writedata (src_wr_writedata),
      .src_wr_byteenable (src_wr_byteenable), .src_wr_user (src_wr_user),
      .src_wr_waitrequest (src_wr_waitrequest),
      .src_wr_writeresponsevalid (src_wr_writeresponsevalid),
      .snk_rd_read (snk_rd_read), .snk_rd_address (snk_rd_address),
      .snk_rd_burstcount (snk_rd_burstcount), .snk_rd_byteenable (snk_rd_byteenable),
      .snk_rd_user (snk_rd_user), .snk_rd_waitrequest (snk_rd_waitrequest),
      .snk_rd_readdata (snk_rd_readdata), .snk_rd_response (snk_rd_response),
      .snk_rd_readdatavalid (snk_rd_readdatavalid),
      .snk_wr_write (snk_wr_write), .snk_wr_address (snk_wr_address),
      .snk_wr_burstcount (snk_wr_burstcount), .snk_wr_writedata (snk_wr_writedata),
      .snk_wr_byteenable (snk_wr_byteenable), .snk_wr_user (snk_wr_user),
      .snk_wr_waitrequest (snk_wr_waitrequest),
      .snk_wr_writeresponsevalid (snk_wr_writeresponsevalid),
      .route_err (route_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int i, input logic rd, input logic [AW-1:0] a, input logic [BW-1:0] bc);
      src_rd_read[i]                = rd;
      src_rd_address[i*AW +: AW]    = a;
      src_rd_burstcount[i*BW +: BW] = bc;
   endtask

   task automatic set_wr(input int i, input logic wr, input logic [BW-1:0] bc, input logic [DW-1:0] d);
      src_wr_write[i]               = wr;
      src_wr_address[i*AW +: AW]    = AW'(16'h0400 + i);
      src_wr_burstcount[i*BW +: BW] = bc;
      src_wr_writedata[i*DW +: DW]  = d;
   endtask

   int         rr_g [5]  = '{0, 1, 2, 3, 0};
   logic [3:0] il_v [5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
   logic [3:0] exp4;

   initial begin
      // Reset with every source and sink input active
      reset_n = 1'b0;
      src_rd_read = '1; src_rd_address = '0; src_rd_burstcount = '0;
      src_rd_byteenable = '1; src_rd_user = '0;
      src_wr_write = '1; src_wr_address = '0; src_wr_burstcount = '0;
      src_wr_writedata = '0; src_wr_byteenable = '1; src_wr_user = '0;
      snk_rd_waitrequest = 1'b0; snk_rd_readdata = '0; snk_rd_response = '0;
      snk_rd_readdatavalid = 1'b1;
      snk_wr_waitrequest = 1'b0; snk_wr_writeresponsevalid = 1'b1;
      #2;
      chk("rst_rd_wait", src_rd_waitrequest, 4'hF);
      chk("rst_wr_wait", src_wr_waitrequest, 4'hF);
      chk("rst_snk_rd_read", snk_rd_read, 1'b0);
      chk("rst_snk_wr_write", snk_wr_write, 1'b0);
      chk("rst_rd_valid", src_rd_readdatavalid, 4'h0);
      chk("rst_wr_resp", src_wr_writeresponsevalid, 4'h0);
      tick();
      chk("rst_route_err", route_err, 1'b0);
      src_rd_read = '0; src_wr_write = '0;
      snk_rd_readdatavalid = 1'b0; snk_wr_writeresponsevalid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Round-robin over four continuous bc=1 readers, responses one cycle behind
      for (int i = 0; i < N; i++) set_rd(i, 1'b1, AW'(16'h0100 + i), 4'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            snk_rd_readdatavalid = 1'b1;
            snk_rd_readdata = DW'(32'hD0 + k - 1);
         end
         #1;
         exp4 = ~(4'b0001 << rr_g[k]);
         chk($sformatf("rr_addr%0d", k), snk_rd_address, 64'(16'h0100 + rr_g[k]));
         chk($sformatf("rr_wait%0d", k), src_rd_waitrequest, exp4);
         if (k > 0) chk($sformatf("rr_rvld%0d", k), src_rd_readdatavalid, 64'(4'b0001 << rr_g[k-1]));
         tick();
      end
      src_rd_read = '0;
      snk_rd_readdata = 32'hD4;
      #1;
      chk("rr_rvld_last", src_rd_readdatavalid, 4'b0001);
      chk("rr_rdata", src_rd_readdata, 32'hD4);
      tick();
      snk_rd_readdatavalid = 1'b0;

      // Interleaving: src0 bc=3 then src2 bc=2 (read pointer now at 1)
      set_rd(0, 1'b1, 16'h0200, 4'd3);
      #1;
      chk("il_bc", snk_rd_burstcount, 4'd3);
      chk("il_wait0", src_rd_waitrequest, 4'b1110);
      tick();
      set_rd(0, 1'b0, 16'h0200, 4'd3);
      set_rd(2, 1'b1, 16'h0220, 4'd2);
      #1;
      chk("il_wait2", src_rd_waitrequest, 4'b1011);
      tick();
      src_rd_read = '0;
      snk_rd_readdatavalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("il_rvld%0d", k), src_rd_readdatavalid, il_v[k]);
         tick();
      end
      // One readdatavalid too many: nothing routed, error flag set
      #1;
      chk("err_rvld", src_rd_readdatavalid, 4'h0);
      tick();
      snk_rd_readdatavalid = 1'b0;
      #1;
      chk("err_flag", route_err, 1'b1);

      // Write lock: src1 bc=4 burst, src0 joins and must wait
      set_wr(1, 1'b1, 4'd4, 32'hA0);
      #1;
      chk("wl_bc", snk_wr_burstcount, 4'd4);
      chk("wl_wait_b0", src_wr_waitrequest, 4'b1101);
      tick();
      set_wr(0, 1'b1, 4'd1, 32'hB0);
      set_wr(1, 1'b1, 4'd4, 32'hA1);
      #1;
      chk("wl_wait_b1", src_wr_waitrequest, 4'b1101);
      chk("wl_data_b1", snk_wr_writedata, 32'hA1);
      tick();
      set_wr(1, 1'b1, 4'd4, 32'hA2);
      snk_wr_waitrequest = 1'b1;
      #1;
      chk("wl_wait_stall", src_wr_waitrequest, 4'b1111);
      tick();
      snk_wr_waitrequest = 1'b0;
      #1;
      chk("wl_wait_b2", src_wr_waitrequest, 4'b1101);
      tick();
      set_wr(1, 1'b1, 4'd4, 32'hA3);
      #1;
      chk("wl_wait_b3", src_wr_waitrequest, 4'b1101);
      tick();
      set_wr(1, 1'b0, 4'd4, 32'hA3);
      #1;
      chk("wl_wait_src0", src_wr_waitrequest, 4'b1110);
      chk("wl_data_src0", snk_wr_writedata, 32'hB0);
      tick();
      src_wr_write = '0;
      snk_wr_writeresponsevalid = 1'b1;
      #1;
      chk("wl_resp1", src_wr_writeresponsevalid, 4'b0010);
      tick();
      chk("wl_resp0", src_wr_writeresponsevalid, 4'b0001);
      tick();
      snk_wr_writeresponsevalid = 1'b0;

      // Full route FIFO: src1 reads continuously, responses stalled
      set_rd(1, 1'b1, 16'h0300, 4'd1);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ff_wait%0d", k), src_rd_waitrequest, 4'b1101);
         tick();
      end
      chk("ff_wait4", src_rd_waitrequest, 4'b1111);
      chk("ff_snk_read", snk_rd_read, 1'b0);
      tick();
      snk_rd_readdatavalid = 1'b1;
      #1;
      chk("ff_wait_pop", src_rd_waitrequest, 4'b1111);
      chk("ff_rvld_pop", src_rd_readdatavalid, 4'b0010);
      tick();
      snk_rd_readdatavalid = 1'b0;
      #1;
      chk("ff_wait_admit", src_rd_waitrequest, 4'b1101);
      tick();
      src_rd_read = '0;
      snk_rd_readdatavalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ff_drain%0d", k), src_rd_readdatavalid, 4'b0010);
         tick();
      end
      snk_rd_readdatavalid = 1'b0;

      // Reset mid-burst: src3 locked in a bc=4 burst (write pointer at 1)
      set_wr(3, 1'b1, 4'd4, 32'hC0);
      #1;
      chk("rb_wait_first", src_wr_waitrequest, 4'b0111);
      tick();
      set_wr(0, 1'b1, 4'd1, 32'hE0);
      #1;
      chk("rb_wait_locked", src_wr_waitrequest, 4'b0111);
      reset_n = 1'b0;
      #1;
      chk("rb_route_err", route_err, 1'b0);
      chk("rb_wr_wait", src_wr_waitrequest, 4'hF);
      chk("rb_rd_wait", src_rd_waitrequest, 4'hF);
      chk("rb_snk_write", snk_wr_write, 1'b0);
      tick();
      reset_n = 1'b1;
      #1;
      chk("rb_idle_grant", src_wr_waitrequest, 4'b1110);
      chk("rb_err_clear", route_err, 1'b0);
      tick();
      src_wr_write = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
